// File: rtl/xy_rr_arbiter.sv
// xy_rr_arbiter
//   Round-robin arbiter with registered grant outputs. A grant is held while
//   the owner keeps requesting; every grant is followed by at least one idle
//   cycle before the next grant is issued.
//
//   Optional feature (compile-time macro XY_ARB_TIMEOUT_EN):
//     Limits a grant to MAX_HOLD consecutive cycles. On a forced release,
//     timeout pulses and the owner is masked until it drops its request.
//     Without the macro, grants are held indefinitely and timeout is tied low.
//
//   Parameters:
//     N        - number of requesters (2..8)
//     MAX_HOLD - hold limit in grant cycles (2..255)
//   Ports:
//     clk     - clock, all state updates on posedge
//     rst_n   - asynchronous active-low reset
//     x_sig   - request vector, bit i = requester i
//     y_sig   - registered one-hot-or-zero grant vector
//     busy    - registered, high while any grant is active
//     timeout - registered one-cycle pulse on forced release
//     owner   - registered index of the current or last owner
module xy_rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         x_sig,
  output logic [N-1:0]         y_sig,
  output logic                 busy,
  output logic                 timeout,
  output logic [$clog2(N)-1:0] owner
);

  localparam int PW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]     state;
  logic [PW-1:0]  ptr;
  logic [HW-1:0]  hold_cnt;
  logic [N-1:0]   mask;
  logic [N-1:0]   eligible;
  logic [2*N-1:0] rot;
  logic           pick_found;
  logic [PW-1:0]  pick_idx;
  logic [PW-1:0]  next_ptr;
  logic           owner_req;
  logic           hold_hit;
  logic           drop_grant;

  assign eligible = x_sig & ~mask;

  // Rotate the doubled request vector so bit 0 is the requester at ptr;
  // the first set bit then gives the round-robin winner as an offset.
  assign rot = {eligible, eligible} >> ptr;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!pick_found && rot[i]) begin
        pick_found = 1'b1;
        pick_idx   = PW'((32'(ptr) + i) % N);
      end
    end
  end

  assign next_ptr   = (owner == PW'(N - 1)) ? '0 : owner + 1'b1;
  assign owner_req  = x_sig[owner];
  assign drop_grant = !owner_req || hold_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      y_sig    <= '0;
      busy     <= 1'b0;
      owner    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else if (state == IDLE) begin
      hold_cnt <= '0;
      if (pick_found) begin
        state    <= GRANT;
        y_sig    <= {{(N-1){1'b0}}, 1'b1} << pick_idx;
        busy     <= 1'b1;
        owner    <= pick_idx;
        hold_cnt <= HW'(1);
      end
    end else begin
      if (drop_grant) begin
        state    <= IDLE;
        y_sig    <= '0;
        busy     <= 1'b0;
        ptr      <= next_ptr;
        hold_cnt <= '0;
      end else if (hold_cnt != HW'(MAX_HOLD)) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

`ifdef XY_ARB_TIMEOUT_EN
  logic           forced;
  logic [N-1:0]   owner_oh;

  assign hold_hit = (hold_cnt == HW'(MAX_HOLD));
  assign forced   = (state == GRANT) && owner_req && hold_hit;
  assign owner_oh = {{(N-1){1'b0}}, 1'b1} << owner;

  // A mask bit clears on any edge where its request is sampled low, and is
  // set for the owner on a forced release (its request is high then).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask    <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= forced;
      mask    <= (mask & x_sig) | (forced ? owner_oh : '0);
    end
  end
`else
  assign hold_hit = 1'b0;
  assign mask     = '0;
  assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_xy_rr_arbiter.sv
module tb_xy_rr_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;

`ifdef XY_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] x_sig = 4'b0000;
  logic [3:0] y_sig;
  logic       busy;
  logic       timeout;
  logic [1:0] owner;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] y;
    logic       busy;
    logic       to;
    logic [1:0] own;
  } exp_t;

  exp_t sb[$];

  // reference model state
  bit         m_grant;
  int         m_ptr;
  int         m_owner;
  int         m_hold;
  logic [3:0] m_mask;
  logic       m_to;

  always #5 clk = ~clk;

  xy_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .x_sig   (x_sig),
    .y_sig   (y_sig),
    .busy    (busy),
    .timeout (timeout),
    .owner   (owner)
  );

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_grant = 1'b0;
    m_ptr   = 0;
    m_owner = 0;
    m_hold  = 0;
    m_mask  = 4'b0000;
    m_to    = 1'b0;
    sb.delete();
  endtask

  // Advance the model by one active edge with request vector x and queue
  // the outputs the DUT must show after that edge.
  task automatic model_edge(input logic [3:0] x);
    exp_t       e;
    logic [3:0] set_m;
    bit         found;
    int         idx;
    set_m = 4'b0000;
    found = 1'b0;
    m_to  = 1'b0;
    if (!m_grant) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!found && x[idx] && !m_mask[idx]) begin
          found   = 1'b1;
          m_grant = 1'b1;
          m_owner = idx;
          m_hold  = 1;
        end
      end
    end else if (!x[m_owner]) begin
      m_grant = 1'b0;
      m_ptr   = (m_owner + 1) % N;
      m_hold  = 0;
    end else if (TO_EN && m_hold == MAX_HOLD) begin
      m_grant        = 1'b0;
      m_to           = 1'b1;
      m_ptr          = (m_owner + 1) % N;
      m_hold         = 0;
      set_m[m_owner] = 1'b1;
    end else if (m_hold < MAX_HOLD) begin
      m_hold++;
    end
    if (TO_EN) m_mask = (m_mask & x) | set_m;
    e.y    = m_grant ? (4'b0001 << m_owner) : 4'b0000;
    e.busy = m_grant;
    e.to   = m_to;
    e.own  = 2'(m_owner);
    sb.push_back(e);
  endtask

  // Drive x on the falling edge (optionally releasing reset at the same
  // time), then compare the DUT against the queued expectation just after
  // the next rising edge.
  task automatic step(input logic [3:0] x, input bit rel = 1'b0);
    exp_t e;
    @(negedge clk);
    if (rel) rst_n = 1'b1;
    x_sig = x;
    model_edge(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("y_sig", y_sig, e.y);
      check("busy", busy, e.busy);
      check("timeout", timeout, e.to);
      check("owner", owner, e.own);
    end
  endtask

  int         order [5];
  logic [3:0] oh;
  logic [3:0] xv;
  int         grants;
  int         tos;

  initial begin
    model_reset();

    // reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_y", y_sig, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_owner", owner, 2'd0);

    // release, request from requester 1 sampled on the third edge
    step(4'b0000, 1'b1);
    step(4'b0000);
    step(4'b0010);
    check("first_grant_y", y_sig, 4'b0010);
    check("first_grant_busy", busy, 1'b1);
    check("first_grant_owner", owner, 2'd1);
    step(4'b0010);
    step(4'b0000);
    check("drop_y", y_sig, 4'b0000);

    // owner 2 holds; a new request from 0 must not disturb it
    step(4'b0100);
    check("own2_y", y_sig, 4'b0100);
    for (int c = 0; c < 3; c++) begin
      step(4'b0101);
      check("own2_hold_y", y_sig, 4'b0100);
    end
    step(4'b0001);
    check("own2_gap_y", y_sig, 4'b0000);
    step(4'b0001);
    check("own0_after_gap_y", y_sig, 4'b0001);
    step(4'b0000);

    // reset mid-grant drops the grant asynchronously without a timeout
    step(4'b1000);
    step(4'b1000);
    check("own3_y", y_sig, 4'b1000);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_y", y_sig, 4'b0000);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_timeout", timeout, 1'b0);
    check("async_rst_owner", owner, 2'd0);
    model_reset();
    step(4'b1001, 1'b1);
    check("post_rst_y", y_sig, 4'b0001);
    step(4'b0000);

    // full request set from ptr 0: order 0,1,2,3,0 with a gap between grants
    @(negedge clk);
    rst_n = 1'b0;
    x_sig = 4'b0000;
    model_reset();
    order = '{0, 1, 2, 3, 0};
    xv    = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      oh = 4'b0001 << order[g];
      step(xv, g == 0);
      check("rr_order_y", y_sig, oh);
      step(xv);
      check("rr_hold_y", y_sig, oh);
      step(xv & ~oh);
      check("rr_gap_y", y_sig, 4'b0000);
    end

`ifdef XY_ARB_TIMEOUT_EN
    // hold limit: 8 grant cycles, one timeout pulse, no regrant while high
    grants = 0;
    tos    = 0;
    for (int c = 0; c < 20; c++) begin
      step(4'b0010);
      if (y_sig === 4'b0010) grants++;
      if (timeout === 1'b1) tos++;
    end
    check("hold_grant_cycles", grants, 8);
    check("timeout_pulses", tos, 1);
    step(4'b0000);
    step(4'b0010);
    check("regrant_after_unmask_y", y_sig, 4'b0010);
    step(4'b0000);
`else
    // without the hold limit a grant is kept indefinitely
    step(4'b1000);
    grants = 0;
    tos    = 0;
    for (int c = 0; c < 50; c++) begin
      step(4'b1000);
      if (y_sig === 4'b1000) grants++;
      if (timeout !== 1'b0) tos++;
    end
    check("long_hold_cycles", grants, 50);
    check("long_hold_timeouts", tos, 0);
    step(4'b0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
